// File: rtl/head_mem_arbiter.sv
// Round-robin arbiter sharing the head-array host memory port among NUM_REQ requesters.
// Read responses are routed back to their issuer through an in-order tag FIFO.
module head_mem_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int ADDR_WIDTH      = 22,
    parameter int DATA_WIDTH      = 16,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_vld,
    output logic [NUM_REQ-1:0]            req_rdy,
    input  logic [NUM_REQ-1:0]            req_wen,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_vld,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    input  logic                          quiesce,
    output logic                          idle,
    input  logic                          err_clr,
    output logic                          err_unexp_rvld,
    output logic [ADDR_WIDTH-1:0]         array_mem_addr,
    output logic [DATA_WIDTH-1:0]         array_mem_wdata,
    output logic                          array_mem_wen,
    output logic                          array_mem_ren,
    input  logic [DATA_WIDTH-1:0]         array_mem_rdata,
    input  logic                          array_mem_rvld
);

    localparam int TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
    localparam logic [TAG_W:0]   NREQ_W  = (TAG_W + 1)'(NUM_REQ);
    localparam logic [TAG_W-1:0] LAST_REQ = TAG_W'(NUM_REQ - 1);

    logic [TAG_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [TAG_W-1:0]      tag_mem_q [MAX_OUTSTANDING];
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  wen_q, ren_q;
    logic [NUM_REQ-1:0]    rsp_vld_q, rsp_vld_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic                  err_q, err_d;

    logic [NUM_REQ-1:0]    elig;
    logic                  grant_vld;
    logic [TAG_W-1:0]      grant_idx;
    logic [TAG_W:0]        scan_idx;
    logic                  push, pop, unexp;

    // Handshake: a requester transfers when req_vld & req_rdy; req_rdy is one-hot
    // or zero and never depends on anything but registered state and current inputs.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = req_vld[i] & ~quiesce & (req_wen[i] | (cnt_q < MAX_CNT));
        end
    end

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, rr_ptr_q} + (TAG_W + 1)'(k);
            if (scan_idx >= NREQ_W) scan_idx = scan_idx - NREQ_W;
            if (!grant_vld && elig[scan_idx[TAG_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = scan_idx[TAG_W-1:0];
            end
        end
    end

    assign req_rdy = grant_vld ? (NUM_REQ'(1) << grant_idx) : '0;

    assign push  = grant_vld & ~req_wen[grant_idx];
    assign pop   = array_mem_rvld & (cnt_q != '0);
    assign unexp = array_mem_rvld & (cnt_q == '0);

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_vld) rr_ptr_d = (grant_idx == LAST_REQ) ? '0 : grant_idx + 1'b1;

        cnt_d = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + 1'b1;
        else if (!push && pop) cnt_d = cnt_q - 1'b1;

        rsp_vld_d = pop ? (NUM_REQ'(1) << tag_mem_q[rd_ptr_q]) : '0;

        // A new stray response outranks a simultaneous clear.
        err_d = err_q;
        if (err_clr) err_d = 1'b0;
        if (unexp)   err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) tag_mem_q[i] <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wen_q       <= 1'b0;
            ren_q       <= 1'b0;
            rsp_vld_q   <= '0;
            rsp_rdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            cnt_q     <= cnt_d;
            rsp_vld_q <= rsp_vld_d;
            err_q     <= err_d;
            wen_q     <= grant_vld &  req_wen[grant_idx];
            ren_q     <= grant_vld & ~req_wen[grant_idx];
            if (grant_vld) begin
                addr_q  <= req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
                wdata_q <= req_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
            end
            if (push) begin
                tag_mem_q[wr_ptr_q] <= grant_idx;
                wr_ptr_q            <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q    <= rd_ptr_q + 1'b1;
                rsp_rdata_q <= array_mem_rdata;
            end
        end
    end

    assign array_mem_addr  = addr_q;
    assign array_mem_wdata = wdata_q;
    assign array_mem_wen   = wen_q;
    assign array_mem_ren   = ren_q;
    assign rsp_vld         = rsp_vld_q;
    assign rsp_rdata       = rsp_rdata_q;
    assign err_unexp_rvld  = err_q;
    assign idle            = (cnt_q == '0) & ~wen_q & ~ren_q;

endmodule
